// File: rtl/nvram_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nvram_pkg
// Brief    : Shared state encoding and ioctl index constants for the
//            NVRAM / hiscore port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package nvram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DL       = 3'd1,
    ST_HS_PAUSE = 3'd2,
    ST_HS_GRANT = 3'd3,
    ST_HS_PAD   = 3'd4
  } state_t;

  localparam logic [7:0] c_rom_index   = 8'd0;
  localparam logic [7:0] c_nvram_index = 8'd4;

endpackage
`default_nettype wire

// File: rtl/nvram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : nvram_port_arbiter_if
// Brief    : Download, hiscore and shared game-memory port signal bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface nvram_port_arbiter_if;

  logic        dl_active;
  logic [7:0]  dl_index;
  logic        dl_wr;
  logic [15:0] dl_addr;
  logic [7:0]  dl_data;

  logic        hs_req;
  logic [9:0]  hs_addr;
  logic        hs_wr;
  logic [7:0]  hs_data;

  logic        cpu_paused;

  logic        pause_req;
  logic        hs_grant;
  logic [15:0] port_addr;
  logic [7:0]  port_data;
  logic        port_rom_wr;
  logic        port_nvram_wr;
  logic        port_nvram_sel;
  logic        timeout_err;

  modport master (
    output dl_active, dl_index, dl_wr, dl_addr, dl_data,
    output hs_req, hs_addr, hs_wr, hs_data, cpu_paused,
    input  pause_req, hs_grant, port_addr, port_data,
    input  port_rom_wr, port_nvram_wr, port_nvram_sel, timeout_err
  );

  modport slave (
    input  dl_active, dl_index, dl_wr, dl_addr, dl_data,
    input  hs_req, hs_addr, hs_wr, hs_data, cpu_paused,
    output pause_req, hs_grant, port_addr, port_data,
    output port_rom_wr, port_nvram_wr, port_nvram_sel, timeout_err
  );

endinterface
`default_nettype wire

// File: rtl/nvram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : nvram_port_arbiter
// Brief    : Shares the game memory port between ioctl download and the
//            hiscore engine, pausing the game CPU around hiscore access.
// Revision : 1.0 - initial release
// ============================================================================
module nvram_port_arbiter
  import nvram_pkg::*;
#(
  parameter logic [7:0]  NVRAM_INDEX   = c_nvram_index,
  parameter logic [15:0] PAUSE_TIMEOUT = 16'd4000,
  parameter int          RELEASE_PAD   = 2
) (
  input  wire logic           clk_sys,
  input  wire logic           reset,
  nvram_port_arbiter_if.slave bus
);

  localparam logic [15:0] c_pad_len   = RELEASE_PAD[15:0];
  localparam state_t      c_pad_entry = (RELEASE_PAD == 0) ? ST_IDLE : ST_HS_PAD;

  state_t      r_state;
  logic [15:0] r_cnt;
  logic        r_pause_req;
  logic        r_hs_grant;
  logic [15:0] r_port_addr;
  logic [7:0]  r_port_data;
  logic        r_port_rom_wr;
  logic        r_port_nvram_wr;
  logic        r_port_nvram_sel;
  logic        r_timeout_err;

  state_t      w_next;
  logic        w_timeout;
  logic [15:0] w_cnt_inc;
  logic [15:0] w_cnt_next;
  logic        w_dl_nvram;
  logic        w_dl_rom;

  assign w_cnt_inc  = r_cnt + 16'd1;
  assign w_dl_nvram = (bus.dl_index == NVRAM_INDEX);
  assign w_dl_rom   = (bus.dl_index == c_rom_index);

  // Download always has priority: the core is held in reset while it runs.
  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.dl_active)   w_next = ST_DL;
        else if (bus.hs_req) w_next = ST_HS_PAUSE;
      end
      ST_DL: begin
        if (!bus.dl_active) w_next = ST_IDLE;
      end
      ST_HS_PAUSE: begin
        if (bus.dl_active)           w_next = ST_DL;
        else if (!bus.hs_req)        w_next = c_pad_entry;
        else if (bus.cpu_paused)     w_next = ST_HS_GRANT;
        else if (w_cnt_inc == PAUSE_TIMEOUT) begin
          w_next    = ST_HS_GRANT;
          w_timeout = 1'b1;
        end
      end
      ST_HS_GRANT: begin
        if (bus.dl_active)    w_next = ST_DL;
        else if (!bus.hs_req) w_next = c_pad_entry;
      end
      ST_HS_PAD: begin
        if (bus.dl_active)             w_next = ST_DL;
        else if (w_cnt_inc >= c_pad_len) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
    // One counter serves both the pause wait and the release pad.
    w_cnt_next = ((w_next == r_state) &&
                  ((r_state == ST_HS_PAUSE) || (r_state == ST_HS_PAD))) ? w_cnt_inc : 16'd0;
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state          <= ST_IDLE;
      r_cnt            <= 16'd0;
      r_pause_req      <= 1'b0;
      r_hs_grant       <= 1'b0;
      r_port_addr      <= 16'd0;
      r_port_data      <= 8'd0;
      r_port_rom_wr    <= 1'b0;
      r_port_nvram_wr  <= 1'b0;
      r_port_nvram_sel <= 1'b0;
      r_timeout_err    <= 1'b0;
    end else begin
      r_state         <= w_next;
      r_cnt           <= w_cnt_next;
      r_pause_req     <= (w_next == ST_HS_PAUSE) || (w_next == ST_HS_GRANT) ||
                         (w_next == ST_HS_PAD);
      r_hs_grant      <= (w_next == ST_HS_GRANT);
      r_port_rom_wr   <= 1'b0;
      r_port_nvram_wr <= 1'b0;
      if (w_timeout) r_timeout_err <= 1'b1;
      case (w_next)
        ST_DL: begin
          r_port_addr      <= bus.dl_addr;
          r_port_data      <= bus.dl_data;
          r_port_nvram_sel <= w_dl_nvram;
          r_port_rom_wr    <= bus.dl_wr && w_dl_rom;
          r_port_nvram_wr  <= bus.dl_wr && w_dl_nvram;
        end
        ST_HS_GRANT: begin
          r_port_addr      <= {6'b0, bus.hs_addr};
          r_port_data      <= bus.hs_data;
          r_port_nvram_sel <= 1'b1;
          r_port_nvram_wr  <= bus.hs_wr;
        end
        default: ;
      endcase
    end
  end

  assign bus.pause_req      = r_pause_req;
  assign bus.hs_grant       = r_hs_grant;
  assign bus.port_addr      = r_port_addr;
  assign bus.port_data      = r_port_data;
  assign bus.port_rom_wr    = r_port_rom_wr;
  assign bus.port_nvram_wr  = r_port_nvram_wr;
  assign bus.port_nvram_sel = r_port_nvram_sel;
  assign bus.timeout_err    = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_nvram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_nvram_port_arbiter
// Brief    : Directed self-checking bench for nvram_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nvram_port_arbiter;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  nvram_port_arbiter_if bus();

  nvram_port_arbiter dut (
    .clk_sys (clk),
    .reset   (reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.dl_active  = 1'b0;
    bus.dl_index   = 8'd0;
    bus.dl_wr      = 1'b0;
    bus.dl_addr    = 16'd0;
    bus.dl_data    = 8'd0;
    bus.hs_req     = 1'b0;
    bus.hs_addr    = 10'd0;
    bus.hs_wr      = 1'b0;
    bus.hs_data    = 8'd0;
    bus.cpu_paused = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Drives the arbiter into HS_GRANT: IDLE -> HS_PAUSE -> HS_GRANT.
  task automatic get_grant();
    bus.hs_req     = 1'b1;
    bus.cpu_paused = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (bus.pause_req !== 1'b0) begin n_fail++; $display("FAIL reset_pause_req: got %b want 0", bus.pause_req); end
    n_checks++; if (bus.hs_grant !== 1'b0) begin n_fail++; $display("FAIL reset_hs_grant: got %b want 0", bus.hs_grant); end
    n_checks++; if ({bus.port_rom_wr, bus.port_nvram_wr, bus.port_nvram_sel, bus.timeout_err} !== 4'b0000)
      begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {bus.port_rom_wr, bus.port_nvram_wr, bus.port_nvram_sel, bus.timeout_err}); end
    n_checks++; if ({bus.port_addr, bus.port_data} !== 24'h0) begin n_fail++; $display("FAIL reset_port: got %h want 000000", {bus.port_addr, bus.port_data}); end
  endtask

  task automatic test_hs_grant();
    int early;
    do_reset();
    bus.hs_req = 1'b1;
    tick();
    n_checks++; if (bus.pause_req !== 1'b1) begin n_fail++; $display("FAIL hs_pause_req_c1: got %b want 1", bus.pause_req); end
    early = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.hs_grant !== 1'b0) early++;
    end
    n_checks++; if (early != 0) begin n_fail++; $display("FAIL hs_grant_early: got %0d grant cycles want 0", early); end
    bus.cpu_paused = 1'b1;
    tick();
    n_checks++; if (bus.hs_grant !== 1'b1) begin n_fail++; $display("FAIL hs_grant_rise: got %b want 1", bus.hs_grant); end
    bus.hs_addr = 10'h3FF;
    bus.hs_data = 8'hA5;
    bus.hs_wr   = 1'b1;
    tick();
    n_checks++; if (bus.port_addr !== 16'h03FF) begin n_fail++; $display("FAIL hs_port_addr: got %h want 03ff", bus.port_addr); end
    n_checks++; if (bus.port_data !== 8'hA5) begin n_fail++; $display("FAIL hs_port_data: got %h want a5", bus.port_data); end
    n_checks++; if ({bus.port_nvram_wr, bus.port_nvram_sel, bus.port_rom_wr} !== 3'b110)
      begin n_fail++; $display("FAIL hs_port_strobes: got %b want 110", {bus.port_nvram_wr, bus.port_nvram_sel, bus.port_rom_wr}); end
    bus.hs_wr = 1'b0;
    tick();
    n_checks++; if (bus.port_nvram_wr !== 1'b0) begin n_fail++; $display("FAIL hs_wr_pulse: got %b want 0", bus.port_nvram_wr); end
  endtask

  task automatic test_release_pad();
    do_reset();
    get_grant();
    bus.hs_req = 1'b0;
    tick();
    n_checks++; if ({bus.pause_req, bus.hs_grant} !== 2'b10) begin n_fail++; $display("FAIL pad_c1: got %b want 10", {bus.pause_req, bus.hs_grant}); end
    tick();
    n_checks++; if (bus.pause_req !== 1'b1) begin n_fail++; $display("FAIL pad_c2: got %b want 1", bus.pause_req); end
    tick();
    n_checks++; if (bus.pause_req !== 1'b0) begin n_fail++; $display("FAIL pad_end: got %b want 0", bus.pause_req); end
  endtask

  task automatic test_download();
    do_reset();
    bus.dl_active = 1'b1;
    bus.dl_index  = 8'd0;
    bus.dl_addr   = 16'h1234;
    bus.dl_data   = 8'h5A;
    bus.dl_wr     = 1'b1;
    tick();
    n_checks++; if ({bus.port_rom_wr, bus.port_nvram_wr, bus.port_nvram_sel} !== 3'b100)
      begin n_fail++; $display("FAIL dl_rom_strobes: got %b want 100", {bus.port_rom_wr, bus.port_nvram_wr, bus.port_nvram_sel}); end
    n_checks++; if ({bus.port_addr, bus.port_data} !== 24'h12345A) begin n_fail++; $display("FAIL dl_rom_port: got %h want 12345a", {bus.port_addr, bus.port_data}); end
    n_checks++; if (bus.pause_req !== 1'b0) begin n_fail++; $display("FAIL dl_pause_req: got %b want 0", bus.pause_req); end
    bus.dl_wr = 1'b0;
    tick();
    n_checks++; if (bus.port_rom_wr !== 1'b0) begin n_fail++; $display("FAIL dl_rom_pulse: got %b want 0", bus.port_rom_wr); end
    bus.dl_index = 8'd4;
    bus.dl_addr  = 16'h0010;
    bus.dl_data  = 8'hC3;
    bus.dl_wr    = 1'b1;
    tick();
    n_checks++; if ({bus.port_rom_wr, bus.port_nvram_wr, bus.port_nvram_sel} !== 3'b011)
      begin n_fail++; $display("FAIL dl_nvram_strobes: got %b want 011", {bus.port_rom_wr, bus.port_nvram_wr, bus.port_nvram_sel}); end
    n_checks++; if ({bus.port_addr, bus.port_data} !== 24'h0010C3) begin n_fail++; $display("FAIL dl_nvram_port: got %h want 0010c3", {bus.port_addr, bus.port_data}); end
    bus.dl_index = 8'd7;
    bus.dl_addr  = 16'h0022;
    tick();
    n_checks++; if ({bus.port_rom_wr, bus.port_nvram_wr, bus.port_nvram_sel} !== 3'b000)
      begin n_fail++; $display("FAIL dl_other_strobes: got %b want 000", {bus.port_rom_wr, bus.port_nvram_wr, bus.port_nvram_sel}); end
    bus.dl_wr     = 1'b0;
    bus.dl_active = 1'b0;
    tick();
    bus.hs_req = 1'b1;
    tick();
    n_checks++; if (bus.pause_req !== 1'b1) begin n_fail++; $display("FAIL dl_exit_idle: got %b want 1", bus.pause_req); end
  endtask

  task automatic test_same_cycle();
    int bad;
    do_reset();
    bus.hs_req    = 1'b1;
    bus.dl_active = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.hs_grant !== 1'b0 || bus.pause_req !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL same_cycle_dl_wins: got %0d bad cycles want 0", bad); end
    bus.dl_active = 1'b0;
    tick();
    tick();
    n_checks++; if (bus.pause_req !== 1'b1) begin n_fail++; $display("FAIL same_cycle_hs_after: got %b want 1", bus.pause_req); end
  endtask

  task automatic test_preempt();
    do_reset();
    get_grant();
    bus.dl_active = 1'b1;
    bus.dl_index  = 8'd9;
    bus.dl_addr   = 16'hBEEF;
    bus.hs_wr     = 1'b1;
    bus.hs_addr   = 10'h155;
    bus.hs_data   = 8'h3C;
    tick();
    n_checks++; if ({bus.hs_grant, bus.pause_req, bus.port_nvram_wr} !== 3'b000)
      begin n_fail++; $display("FAIL preempt_flags: got %b want 000", {bus.hs_grant, bus.pause_req, bus.port_nvram_wr}); end
    n_checks++; if (bus.port_addr !== 16'hBEEF) begin n_fail++; $display("FAIL preempt_addr: got %h want beef", bus.port_addr); end
  endtask

  task automatic test_hs_abort();
    int grants;
    do_reset();
    bus.hs_req = 1'b1;
    tick();
    bus.hs_req     = 1'b0;
    bus.cpu_paused = 1'b1;
    grants = 0;
    tick();
    n_checks++; if (bus.pause_req !== 1'b1) begin n_fail++; $display("FAIL abort_pad: got %b want 1", bus.pause_req); end
    if (bus.hs_grant !== 1'b0) grants++;
    tick();
    if (bus.hs_grant !== 1'b0) grants++;
    tick();
    if (bus.hs_grant !== 1'b0) grants++;
    n_checks++; if (bus.pause_req !== 1'b0) begin n_fail++; $display("FAIL abort_end: got %b want 0", bus.pause_req); end
    n_checks++; if (grants != 0) begin n_fail++; $display("FAIL abort_no_grant: got %0d want 0", grants); end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    get_grant();
    bus.hs_addr = 10'h2AB;
    bus.hs_data = 8'h77;
    bus.hs_wr   = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    n_checks++; if ({bus.pause_req, bus.hs_grant, bus.port_nvram_wr, bus.port_nvram_sel} !== 4'b0000)
      begin n_fail++; $display("FAIL rst_grant_flags: got %b want 0000", {bus.pause_req, bus.hs_grant, bus.port_nvram_wr, bus.port_nvram_sel}); end
    n_checks++; if ({bus.port_addr, bus.port_data} !== 24'h0) begin n_fail++; $display("FAIL rst_grant_port: got %h want 000000", {bus.port_addr, bus.port_data}); end
    reset = 1'b0;
    clear_inputs();
  endtask

  task automatic test_timeout();
    int cyc;
    int early;
    do_reset();
    bus.hs_req = 1'b1;
    tick();
    cyc   = 0;
    early = 0;
    for (int i = 0; i < 5000; i++) begin
      tick();
      cyc++;
      if (bus.hs_grant === 1'b1) break;
      if (bus.timeout_err !== 1'b0) early++;
    end
    n_checks++; if (cyc != 4000) begin n_fail++; $display("FAIL timeout_cycles: got %0d want 4000", cyc); end
    n_checks++; if ({bus.hs_grant, bus.timeout_err} !== 2'b11) begin n_fail++; $display("FAIL timeout_flags: got %b want 11", {bus.hs_grant, bus.timeout_err}); end
    n_checks++; if (early != 0) begin n_fail++; $display("FAIL timeout_early: got %0d want 0", early); end
    bus.hs_req = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    n_checks++; if (bus.timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: got %b want 1", bus.timeout_err); end
    do_reset();
    n_checks++; if (bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL timeout_reset: got %b want 0", bus.timeout_err); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    clear_inputs();
    test_reset();
    test_hs_grant();
    test_release_pad();
    test_download();
    test_same_cycle();
    test_preempt();
    test_hs_abort();
    test_reset_mid_grant();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nvram_port_arbiter.md
NVRAM_PORT_ARBITER -- requirements
Module: nvram_port_arbiter

Interface
REQ-001 Parameter NVRAM_INDEX, default 8'd4: ioctl index that selects an NVRAM image load.
REQ-002 Parameter PAUSE_TIMEOUT, default 16'd4000: maximum cycles to wait for pause acknowledge.
REQ-003 Parameter RELEASE_PAD, default 2: cycles pause_req stays high after a grant ends.
REQ-004 clk_sys  in  1: single clock; all logic on its rising edge.
REQ-005 reset  in  1: synchronous, active-high reset.
REQ-006 dl_active  in  1: ioctl download in progress.
REQ-007 dl_index  in  8: ioctl index.
REQ-008 dl_wr  in  1: download byte strobe.
REQ-009 dl_addr  in  16: download address.
REQ-010 dl_data  in  8: download byte.
REQ-011 hs_req  in  1: hiscore engine requests the port (level).
REQ-012 hs_addr  in  10: hiscore RAM address.
REQ-013 hs_wr  in  1: hiscore write strobe.
REQ-014 hs_data  in  8: hiscore write byte.
REQ-015 cpu_paused  in  1: game CPU halted acknowledge.
REQ-016 pause_req  out  1: request to halt the game CPU.
REQ-017 hs_grant  out  1: hiscore engine owns the port.
REQ-018 port_addr  out  16, port_data  out  8, port_rom_wr  out  1, port_nvram_wr  out  1, port_nvram_sel  out  1: shared game memory port.
REQ-019 timeout_err  out  1: sticky flag, pause acknowledge not received in time.

Function
REQ-020 States: IDLE, DL, HS_PAUSE, HS_GRANT, HS_PAD.
REQ-021 IDLE: dl_active=1 -> DL, else hs_req=1 -> HS_PAUSE; dl_active wins on a same-cycle request.
REQ-022 DL: port_addr=dl_addr, port_data=dl_data, port_nvram_sel=(dl_index==NVRAM_INDEX); port_rom_wr=dl_wr when dl_index==0; port_nvram_wr=dl_wr when index matches; no output write for any other index.
REQ-023 DL exits to IDLE the cycle after dl_active falls; pause_req is 0 in DL, because the core is held in reset during download.
REQ-024 HS_PAUSE: pause_req=1 and a 16-bit wait counter increments; cpu_paused=1 -> HS_GRANT; counter==PAUSE_TIMEOUT -> set timeout_err, go to HS_GRANT.
REQ-025 HS_GRANT: hs_grant=1; port_addr={6'b0,hs_addr}; port_data=hs_data; port_nvram_wr=hs_wr; port_nvram_sel=1; port_rom_wr=0.
REQ-026 HS_GRANT: hs_req falling -> HS_PAD; dl_active rising preempts: hs_grant drops that same cycle, next state DL; an in-flight hs_wr in that cycle is dropped.
REQ-027 HS_PAD: pause_req=1 and hs_grant=0 for RELEASE_PAD cycles, then IDLE; dl_active during pad -> DL immediately.
REQ-028 If hs_req drops in HS_PAUSE, return to IDLE via HS_PAD with no grant issued.
REQ-029 In all states except DL and HS_GRANT, port write strobes are 0 and port_addr/port_data hold their last value.
REQ-030 Port outputs are registered: one cycle latency from dl_*/hs_* inputs to port_*.
REQ-031 hs_grant is registered and asserts the cycle after cpu_paused is sampled high.
REQ-032 timeout_err clears only on reset.

Reset
REQ-033 On reset: state IDLE; pause_req, hs_grant, port_rom_wr, port_nvram_wr, port_nvram_sel and timeout_err are 0; port_addr and port_data are 0; all counters are 0.
REQ-034 Reset asserted mid-grant releases pause_req and hs_grant on the next edge, with no pad.

Structure
REQ-035 State enum and the NVRAM_INDEX and ROM index constants live in a shared package (nvram_pkg).
REQ-036 There is no sub-module; the wait/pad counter is shared between HS_PAUSE and HS_PAD.

Verification
REQ-037 hs_req=1, cpu_paused rises 5 cycles later -> pause_req at cycle 1; hs_grant 1 cycle after cpu_paused; hs_wr with addr 0x3FF and data 0xA5 -> port_addr 0x03FF, port_nvram_wr=1.
REQ-038 dl_active=1, index 0, writes 0x1234/0x5A -> port_rom_wr pulse one cycle later, port_nvram_sel=0; with index 4 -> port_nvram_wr pulse, port_nvram_sel=1.
REQ-039 hs_req and dl_active asserted in the same cycle -> DL entered; hs_grant never asserts; pause_req stays 0.
REQ-040 hs_req held, cpu_paused held 0 -> timeout_err=1 and hs_grant=1 after 4000 cycles (PAUSE_TIMEOUT=4000).
REQ-041 In HS_GRANT, dl_active rises together with hs_wr -> hs_grant=0 the next cycle; no nvram write is issued for that hs_wr.
REQ-042 hs_req drops -> pause_req stays 1 for exactly 2 more cycles; reset mid-grant -> all outputs 0 on the next edge.
